// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the pattern -> BCD decode used by both the
// display driver and the scan decoder.
//   SEG_0..SEG_9 : active-low g..a patterns for digits 0-9
//   SEG_ILLEGAL  : BCD code reported for any pattern that is not a digit
//   seg7_to_bcd_f: returns {valid, bcd}; exact match only
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [3:0] SEG_ILLEGAL = 4'hF;

  function automatic logic [4:0] seg7_to_bcd_f(input logic [6:0] seg_n);
    logic [4:0] res;
    case (seg_n)
      SEG_0:   res = {1'b1, 4'd0};
      SEG_1:   res = {1'b1, 4'd1};
      SEG_2:   res = {1'b1, 4'd2};
      SEG_3:   res = {1'b1, 4'd3};
      SEG_4:   res = {1'b1, 4'd4};
      SEG_5:   res = {1'b1, 4'd5};
      SEG_6:   res = {1'b1, 4'd6};
      SEG_7:   res = {1'b1, 4'd7};
      SEG_8:   res = {1'b1, 4'd8};
      SEG_9:   res = {1'b1, 4'd9};
      default: res = {1'b0, SEG_ILLEGAL};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low 7-segment pattern.
//   seg_n : segments g..a, active-low
//   valid : 1 when seg_n is exactly one of the ten digit patterns
//   bcd   : decoded digit, SEG_ILLEGAL when not valid
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic       valid,
  output logic [3:0] bcd
);

  always_comb begin
    {valid, bcd} = seg7_to_bcd_f(seg_n);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus.
// The bus is sampled once per stable dwell of {dig_sel, seg_in}; decoded
// digits collect in a shadow frame and are published once every digit has
// been seen.
//   clk, rst    : clock, asynchronous active-high reset
//   seg_in      : [7]=dp, [6:0]=g..a, all active-low
//   dig_sel     : one-hot digit strobe
//   bcd_out     : digit i at [4i+3:4i], 4'hF for an illegal pattern
//   dp_out      : decimal point per digit, 1 = lit
//   err_out     : digit held an illegal pattern in the last frame
//   frame_valid : one-cycle pulse when the outputs above update
//   sel_err     : one-cycle pulse per dwell with a non-one-hot strobe
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG   = 4,
  parameter int unsigned SETTLE = 3
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [NDIG-1:0]   dp_out,
  output logic [NDIG-1:0]   err_out,
  output logic              frame_valid,
  output logic              sel_err
);

  localparam int unsigned    CW      = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SETTLE);
  localparam logic [CW-1:0]  CNT_PRE = CW'(SETTLE - 1);

  logic [NDIG+7:0]   cur_in;
  logic [NDIG+7:0]   prev_q, prev_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sampled_q, sampled_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic [4*NDIG-1:0] sh_bcd_q, sh_bcd_d;
  logic [NDIG-1:0]   sh_dp_q, sh_dp_d;
  logic [NDIG-1:0]   sh_err_q, sh_err_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic [NDIG-1:0]   dp_q, dp_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sel_err_q, sel_err_d;

  logic              changed;
  logic              settle_hit;
  logic              sample;
  logic              publish;
  logic              sel_onehot;
  logic [NDIG-1:0]   sel_m1;
  logic              dec_valid;
  logic [3:0]        dec_bcd;

  seg7_to_bcd u_dec (
    .seg_n (seg_in[6:0]),
    .valid (dec_valid),
    .bcd   (dec_bcd)
  );

  assign cur_in = {dig_sel, seg_in};

  // Clearing the lowest set bit leaves zero only for a single-bit strobe.
  always_comb begin
    sel_m1     = dig_sel - NDIG'(1);
    sel_onehot = (dig_sel != '0) && ((dig_sel & sel_m1) == '0);
  end

  // Dwell tracking: settle_hit fires on the single edge the count reaches SETTLE.
  always_comb begin
    changed   = (cur_in != prev_q);
    prev_d    = cur_in;
    cnt_d     = cnt_q;
    sampled_d = sampled_q;
    if (changed) begin
      cnt_d     = '0;
      sampled_d = 1'b0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    settle_hit = !changed && (cnt_q == CNT_PRE);
    sample     = settle_hit && sel_onehot && !sampled_q;
    sel_err_d  = settle_hit && !sel_onehot;
    if (sample) begin
      sampled_d = 1'b1;
    end
  end

  // Publish copies the pre-edge shadow; a sample on the same edge lands in
  // the shadow and in the freshly cleared mask, so it belongs to the next frame.
  always_comb begin
    publish       = &mask_q;
    mask_d        = publish ? '0 : mask_q;
    sh_bcd_d      = sh_bcd_q;
    sh_dp_d       = sh_dp_q;
    sh_err_d      = sh_err_q;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (sample && dig_sel[i]) begin
        sh_bcd_d[4*i +: 4] = dec_bcd;
        sh_dp_d[i]         = ~seg_in[7];
        sh_err_d[i]        = ~dec_valid;
        mask_d[i]          = 1'b1;
      end
    end
    bcd_d         = publish ? sh_bcd_q : bcd_q;
    dp_d          = publish ? sh_dp_q  : dp_q;
    err_d         = publish ? sh_err_q : err_q;
    frame_valid_d = publish;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q        <= '0;
      cnt_q         <= '0;
      sampled_q     <= 1'b0;
      mask_q        <= '0;
      sh_bcd_q      <= '0;
      sh_dp_q       <= '0;
      sh_err_q      <= '0;
      bcd_q         <= '0;
      dp_q          <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      sampled_q     <= sampled_d;
      mask_q        <= mask_d;
      sh_bcd_q      <= sh_bcd_d;
      sh_dp_q       <= sh_dp_d;
      sh_err_q      <= sh_err_d;
      bcd_q         <= bcd_d;
      dp_q          <= dp_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign dp_out      = dp_q;
  assign err_out     = err_q;
  assign frame_valid = frame_valid_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: table of dwells with hand-computed outputs,
// hand-written corner sequences, then random dwells against a frame-level model.
module tb_seg7_scan_decoder;

  localparam int unsigned NDIG   = 4;
  localparam int unsigned SETTLE = 3;

  logic              clk;
  logic              rst;
  logic [7:0]        seg_in;
  logic [NDIG-1:0]   dig_sel;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0]   dp_out;
  logic [NDIG-1:0]   err_out;
  logic              frame_valid;
  logic              sel_err;

  seg7_scan_decoder #(.NDIG(NDIG), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .dp_out      (dp_out),
    .err_out     (err_out),
    .frame_valid (frame_valid),
    .sel_err     (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Digit patterns written out independently of the design package.
  logic [6:0] pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int lens [6] = '{1, 2, 5, 6, 7, 8};

  // Frame-level reference: shadow slots, seen-mask and published frame.
  int m_sh_bcd  [NDIG];
  bit m_sh_dp   [NDIG];
  bit m_sh_err  [NDIG];
  bit m_mask    [NDIG];
  int m_pub_bcd [NDIG];
  bit m_pub_dp  [NDIG];
  bit m_pub_err [NDIG];

  logic [NDIG+7:0] last_in;

  typedef struct {
    logic [NDIG-1:0]   sel;
    logic [7:0]        seg;
    int                len;
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   err;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic int ref_dec(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (pats[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDIG; i++) begin
      m_sh_bcd[i] = 0; m_sh_dp[i] = 0; m_sh_err[i] = 0; m_mask[i] = 0;
      m_pub_bcd[i] = 0; m_pub_dp[i] = 0; m_pub_err[i] = 0;
    end
  endtask

  // A dwell of len cycles is sampled when it lasts SETTLE cycles past its
  // first edge; the frame is then published one cycle after the last sample.
  task automatic model_dwell(input logic [NDIG-1:0] sel, input logic [7:0] seg,
                             input int len, output bit e_fv, output bit e_se);
    int ones = 0;
    int idx  = 0;
    int d;
    bit full;
    e_fv = 0;
    e_se = 0;
    for (int i = 0; i < NDIG; i++) if (sel[i]) begin ones++; idx = i; end
    if (len >= SETTLE + 2) begin
      if (ones == 1) begin
        d = ref_dec(seg[6:0]);
        m_sh_bcd[idx] = (d < 0) ? 15 : d;
        m_sh_err[idx] = (d < 0);
        m_sh_dp[idx]  = !seg[7];
        m_mask[idx]   = 1;
        full = 1;
        for (int i = 0; i < NDIG; i++) if (!m_mask[i]) full = 0;
        if (full) begin
          for (int i = 0; i < NDIG; i++) begin
            m_pub_bcd[i] = m_sh_bcd[i];
            m_pub_dp[i]  = m_sh_dp[i];
            m_pub_err[i] = m_sh_err[i];
            m_mask[i]    = 0;
          end
          e_fv = 1;
        end
      end else begin
        e_se = 1;
      end
    end
  endtask

  task automatic apply(input logic [NDIG-1:0] sel, input logic [7:0] seg, input int len,
                       output int fv_n, output int fv_at, output int se_n, output int se_at);
    fv_n = 0; fv_at = 0; se_n = 0; se_at = 0;
    dig_sel = sel;
    seg_in  = seg;
    last_in = {sel, seg};
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (frame_valid === 1'b1) begin fv_n++; if (fv_at == 0) fv_at = k; end
      if (sel_err === 1'b1)     begin se_n++; if (se_at == 0) se_at = k; end
    end
  endtask

  task automatic check_model_outputs();
    logic [4*NDIG-1:0] eb;
    logic [NDIG-1:0]   ed, ee;
    for (int i = 0; i < NDIG; i++) begin
      eb[4*i +: 4] = 4'(m_pub_bcd[i]);
      ed[i]        = m_pub_dp[i];
      ee[i]        = m_pub_err[i];
    end
    check("bcd_out", 32'(bcd_out), 32'(eb));
    check("dp_out",  32'(dp_out),  32'(ed));
    check("err_out", 32'(err_out), 32'(ee));
  endtask

  task automatic run_dwell(input logic [NDIG-1:0] sel, input logic [7:0] seg, input int len);
    int fv_n, fv_at, se_n, se_at;
    bit e_fv, e_se;
    model_dwell(sel, seg, len, e_fv, e_se);
    apply(sel, seg, len, fv_n, fv_at, se_n, se_at);
    check("frame_valid_pulses", 32'(fv_n), 32'(e_fv));
    check("sel_err_pulses",     32'(se_n), 32'(e_se));
    if (e_fv) check("frame_latency",  32'(fv_at), 32'(SETTLE + 2));
    if (e_se) check("sel_err_timing", 32'(se_at), 32'(SETTLE + 1));
    check_model_outputs();
  endtask

  initial begin
    logic [NDIG-1:0] s;
    logic [7:0]      g;
    int              r;

    tbl[0]  = '{4'b0001, 8'hC0, 5, 16'h0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0010, 8'hF9, 5, 16'h0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0100, 8'hA4, 5, 16'h0000, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1000, 8'hB0, 5, 16'h3210, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0001, 8'hC0, 5, 16'h3210, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0010, 8'hF9, 5, 16'h3210, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0100, 8'h7F, 5, 16'h3210, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b1000, 8'hB0, 5, 16'h3F10, 4'b0100, 4'b0100};
    tbl[8]  = '{4'b0001, 8'hC0, 5, 16'h3F10, 4'b0100, 4'b0100};
    tbl[9]  = '{4'b0010, 8'hF9, 2, 16'h3F10, 4'b0100, 4'b0100};
    tbl[10] = '{4'b0100, 8'hA4, 5, 16'h3F10, 4'b0100, 4'b0100};
    tbl[11] = '{4'b1000, 8'hB0, 5, 16'h3F10, 4'b0100, 4'b0100};
    tbl[12] = '{4'b0010, 8'hF9, 5, 16'h3210, 4'b0000, 4'b0000};

    rst     = 1'b1;
    dig_sel = '0;
    seg_in  = '0;
    last_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_bcd_out",     32'(bcd_out),     32'h0);
    check("reset_dp_out",      32'(dp_out),      32'h0);
    check("reset_err_out",     32'(err_out),     32'h0);
    check("reset_frame_valid", 32'(frame_valid), 32'h0);
    check("reset_sel_err",     32'(sel_err),     32'h0);
    rst = 1'b0;

    // Frames, illegal blank digit, and a too-short dwell.
    for (int i = 0; i < 13; i++) begin
      run_dwell(tbl[i].sel, tbl[i].seg, tbl[i].len);
      check("tbl_bcd_out", 32'(bcd_out), 32'(tbl[i].bcd));
      check("tbl_dp_out",  32'(dp_out),  32'(tbl[i].dp));
      check("tbl_err_out", 32'(err_out), 32'(tbl[i].err));
    end

    // Non-one-hot strobes must not touch the mask: digits 2,3 alone stay silent.
    run_dwell(4'b0011, 8'hC0, 10);
    run_dwell(4'b0000, 8'hC0, 10);
    run_dwell(4'b0100, 8'hA4, 5);
    run_dwell(4'b1000, 8'hB0, 5);
    run_dwell(4'b0001, 8'h99, 5);
    run_dwell(4'b0010, 8'h92, 5);
    check("onehot_frame_bcd", 32'(bcd_out), 32'h3254);

    // Latest sample of a digit wins.
    run_dwell(4'b0001, 8'h90, 5);
    run_dwell(4'b0001, 8'h80, 5);
    run_dwell(4'b0010, 8'hC0, 5);
    run_dwell(4'b0100, 8'hF9, 5);
    run_dwell(4'b1000, 8'hA4, 5);
    check("resample_bcd", 32'(bcd_out), 32'h2108);

    // Reset mid-frame clears outputs at once and discards the partial frame.
    run_dwell(4'b0001, 8'h99, 5);
    run_dwell(4'b0010, 8'h92, 5);
    run_dwell(4'b0100, 8'h82, 5);
    #2;
    rst     = 1'b1;
    dig_sel = '0;
    seg_in  = '0;
    last_in = '0;
    #1;
    check("async_rst_bcd_out", 32'(bcd_out),     32'h0);
    check("async_rst_dp_out",  32'(dp_out),      32'h0);
    check("async_rst_err_out", 32'(err_out),     32'h0);
    check("async_rst_fv",      32'(frame_valid), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_dwell(4'b1000, 8'h78, 6);
    run_dwell(4'b0001, 8'hC0, 5);
    run_dwell(4'b0010, 8'hF9, 5);
    run_dwell(4'b0100, 8'hA4, 5);
    check("post_rst_frame_bcd", 32'(bcd_out), 32'h7210);

    // Random dwells against the model.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 85) s = NDIG'(1) << $urandom_range(0, NDIG - 1);
      else if (r < 92) s = '0;
      else begin
        s = NDIG'($urandom);
        s[0] = 1'b1;
        s[1] = 1'b1;
      end
      if ($urandom_range(0, 99) < 75) g = {1'($urandom_range(0, 1)), pats[$urandom_range(0, 9)]};
      else g = 8'($urandom);
      if ({s, g} == last_in) g[0] = ~g[0];
      run_dwell(s, g, lens[$urandom_range(0, 5)]);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
